// File: rtl/arm_sequence_controller_if.sv
// Position-ROM read port: address and strobe from the sequencer, data back from memory.
interface arm_sequence_controller_if #(
    parameter int unsigned DATA_WIDTH    = 30,
    parameter int unsigned ADDRESS_WIDTH = 4
);
    logic [ADDRESS_WIDTH-1:0] rom_addr;
    logic                     rom_rd;
    logic [DATA_WIDTH-1:0]    rom_data;

    modport master (output rom_addr, output rom_rd, input rom_data);
    modport slave  (input rom_addr, input rom_rd, output rom_data);
endinterface

// File: rtl/arm_sequence_controller.sv
// Steps through the arm position ROM, unpacks each word into X/Y/Z and dwells
// HOLD_CYCLES clocks per position; supports single-shot stepping and looping.
module arm_sequence_controller #(
    parameter int unsigned           DATA_WIDTH    = 30,
    parameter int unsigned           ADDRESS_WIDTH = 4,
    parameter int unsigned           NUM_POSITIONS = 16,
    parameter int unsigned           HOLD_CYCLES   = 50_000_000,
    parameter logic [DATA_WIDTH-1:0] END_MARKER    = 30'h3FFF_FFFF
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    input  logic                           stop,
    input  logic                           step,
    input  logic                           loop_en,
    arm_sequence_controller_if.master      rom,
    output logic [9:0]                     x_out,
    output logic [9:0]                     y_out,
    output logic [9:0]                     z_out,
    output logic                           pos_valid,
    output logic                           busy,
    output logic                           done
);

    localparam int unsigned CNT_W = $clog2(HOLD_CYCLES + 1);
    localparam logic [ADDRESS_WIDTH-1:0] LAST_ADDR = ADDRESS_WIDTH'(NUM_POSITIONS - 1);
    localparam logic [CNT_W-1:0]         HOLD_LAST = CNT_W'(HOLD_CYCLES);

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_READ = 3'd1;
    localparam logic [2:0] ST_WAIT = 3'd2;
    localparam logic [2:0] ST_HOLD = 3'd3;
    localparam logic [2:0] ST_DONE = 3'd4;

    logic [2:0]               state_q,  state_d;
    logic [ADDRESS_WIDTH-1:0] addr_q,   addr_d;
    logic                     rd_q,     rd_d;
    logic [9:0]               x_q, y_q, z_q, x_d, y_d, z_d;
    logic                     pv_q,     pv_d;
    logic                     busy_q,   busy_d;
    logic                     done_q,   done_d;
    logic [CNT_W-1:0]         cnt_q,    cnt_d;
    logic                     single_q, single_d;
    logic [ADDRESS_WIDTH-1:0] addr_wrap_c;

    // Single-shot advance wraps back to the first entry after the last one
    assign addr_wrap_c = (addr_q >= LAST_ADDR) ? '0 : addr_q + ADDRESS_WIDTH'(1);

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        x_d      = x_q;
        y_d      = y_q;
        z_d      = z_q;
        pv_d     = 1'b0;
        cnt_d    = cnt_q;
        single_d = single_q;

        if (stop) begin
            state_d  = ST_IDLE;
            cnt_d    = '0;
            single_d = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        addr_d   = '0;
                        single_d = 1'b0;
                        state_d  = ST_READ;
                    end else if (step) begin
                        single_d = 1'b1;
                        state_d  = ST_READ;
                    end
                end
                ST_READ: state_d = ST_WAIT;
                ST_WAIT: begin
                    if (rom.rom_data == END_MARKER) begin
                        if (single_q) begin
                            addr_d   = '0;
                            single_d = 1'b0;
                            state_d  = ST_IDLE;
                        end else begin
                            state_d  = ST_DONE;
                        end
                    end else begin
                        x_d  = rom.rom_data[29:20];
                        y_d  = rom.rom_data[19:10];
                        z_d  = rom.rom_data[9:0];
                        pv_d = 1'b1;
                        if (single_q) begin
                            addr_d   = addr_wrap_c;
                            single_d = 1'b0;
                            state_d  = ST_IDLE;
                        end else begin
                            cnt_d    = '0;
                            state_d  = ST_HOLD;
                        end
                    end
                end
                ST_HOLD: begin
                    // Dwell ends once HOLD_CYCLES cycles have been counted
                    if (cnt_q == HOLD_LAST) begin
                        if (addr_q < LAST_ADDR) begin
                            addr_d  = addr_q + ADDRESS_WIDTH'(1);
                            state_d = ST_READ;
                        end else if (loop_en) begin
                            addr_d  = '0;
                            state_d = ST_READ;
                        end else begin
                            state_d = ST_DONE;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                ST_DONE: begin
                    if (start) begin
                        addr_d  = '0;
                        state_d = ST_READ;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end

        rd_d   = (state_d == ST_READ);
        busy_d = (state_d == ST_READ) || (state_d == ST_WAIT) || (state_d == ST_HOLD);
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            addr_q   <= '0;
            rd_q     <= 1'b0;
            x_q      <= '0;
            y_q      <= '0;
            z_q      <= '0;
            pv_q     <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            cnt_q    <= '0;
            single_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            rd_q     <= rd_d;
            x_q      <= x_d;
            y_q      <= y_d;
            z_q      <= z_d;
            pv_q     <= pv_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            cnt_q    <= cnt_d;
            single_q <= single_d;
        end
    end

    assign rom.rom_addr = addr_q;
    assign rom.rom_rd   = rd_q;
    assign x_out        = x_q;
    assign y_out        = y_q;
    assign z_out        = z_q;
    assign pos_valid    = pv_q;
    assign busy         = busy_q;
    assign done         = done_q;

endmodule

// File: tb/tb_arm_sequence_controller.sv
// Directed bench for arm_sequence_controller with a 3-entry ROM and a 4-cycle dwell.
module tb_arm_sequence_controller;

    localparam int unsigned DW = 30;
    localparam int unsigned AW = 4;
    localparam logic [DW-1:0] END_WORD = 30'h3FFF_FFFF;

    logic clk, rst, start, stop, step, loop_en;
    logic [9:0] x_out, y_out, z_out;
    logic pos_valid, busy, done;
    logic [DW-1:0] rom_mem [16];

    int n_total = 0;
    int n_bad   = 0;
    int cyc     = 0;
    int start_cyc;
    int pv_cyc[$];
    int pv_x[$];
    int pv_y[$];
    int pv_z[$];
    int rd_addr[$];

    arm_sequence_controller_if #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW)) rom_if ();

    arm_sequence_controller #(
        .DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .NUM_POSITIONS(3),
        .HOLD_CYCLES(4), .END_MARKER(END_WORD)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .step(step),
        .loop_en(loop_en), .rom(rom_if), .x_out(x_out), .y_out(y_out),
        .z_out(z_out), .pos_valid(pos_valid), .busy(busy), .done(done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Synchronous ROM: data valid the cycle after the strobe
    always @(posedge clk) begin
        if (rom_if.rom_rd) rom_if.rom_data <= rom_mem[rom_if.rom_addr];
    end

    // Record every pos_valid pulse and read strobe with its cycle number
    always @(posedge clk) begin
        if (pos_valid) begin
            pv_cyc.push_back(cyc);
            pv_x.push_back(int'(x_out));
            pv_y.push_back(int'(y_out));
            pv_z.push_back(int'(z_out));
        end
        if (rom_if.rom_rd) rd_addr.push_back(int'(rom_if.rom_addr));
        cyc <= cyc + 1;
    end

    task automatic check(input string tag, input int got, input int exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse(input logic s, input logic p, input logic t);
        start_cyc = cyc;
        start = s; stop = p; step = t;
        @(negedge clk);
        start = 1'b0; stop = 1'b0; step = 1'b0;
    endtask

    task automatic clear_log();
        pv_cyc.delete(); pv_x.delete(); pv_y.delete(); pv_z.delete();
        rd_addr.delete();
    endtask

    task automatic check_xyz(input string tag, input int x, input int y, input int z);
        check({tag, "_x"}, int'(x_out), x);
        check({tag, "_y"}, int'(y_out), y);
        check({tag, "_z"}, int'(z_out), z);
    endtask

    function automatic int pv_at(input int i);
        return (pv_cyc.size() > i) ? pv_cyc[i] : -1;
    endfunction

    function automatic int rd_at(input int i);
        return (rd_addr.size() > i) ? rd_addr[i] : -1;
    endfunction

    initial begin
        #100_000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int c0;
        int found;
        int exp_addr [3];
        int exp_x    [3];
        int exp_y    [3];
        int exp_z    [3];
        exp_addr = '{1, 2, 0};
        exp_x = '{1, 3, 5};
        exp_y = '{2, 3, 5};
        exp_z = '{2, 4, 6};

        start = 0; stop = 0; step = 0; loop_en = 0; rst = 0;
        for (int i = 0; i < 16; i++) rom_mem[i] = '0;
        rom_mem[0] = 30'h0010_0802;
        rom_mem[1] = 30'h0030_0C04;
        rom_mem[2] = 30'h0050_1406;

        // Reset values
        tick(2);
        check("rst_addr", int'(rom_if.rom_addr), 0);
        check("rst_rd", int'(rom_if.rom_rd), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_pv", int'(pos_valid), 0);
        check_xyz("rst", 0, 0, 0);
        rst = 1;
        tick(1);

        // Full run, no loop
        clear_log();
        pulse(1, 0, 0);
        c0 = start_cyc;
        check("t1_rd_first", int'(rom_if.rom_rd), 1);
        check("t1_busy", int'(busy), 1);
        tick(25);
        check("t1_pv_count", pv_cyc.size(), 3);
        check("t1_latency", pv_at(0) - c0, 3);
        check("t1_gap0", pv_at(1) - pv_at(0), 7);
        check("t1_gap1", pv_at(2) - pv_at(1), 7);
        for (int i = 0; i < 3; i++) begin
            check("t1_pos_x", (pv_x.size() > i) ? pv_x[i] : -1, exp_x[i]);
            check("t1_pos_y", (pv_y.size() > i) ? pv_y[i] : -1, exp_y[i]);
            check("t1_pos_z", (pv_z.size() > i) ? pv_z[i] : -1, exp_z[i]);
        end
        check("t1_rd_count", rd_addr.size(), 3);
        check("t1_done", int'(done), 1);
        check("t1_busy_end", int'(busy), 0);

        // Looping, then stop mid-HOLD
        clear_log();
        loop_en = 1;
        pulse(1, 0, 0);
        tick(24);
        check("t2_rd_count", rd_addr.size(), 4);
        check("t2_wrap_addr", rd_at(3), 0);
        check("t2_done", int'(done), 0);
        check("t2_in_hold", int'(busy), 1);
        pulse(0, 1, 0);
        check("t2_stop_busy", int'(busy), 0);
        check("t2_stop_done", int'(done), 0);
        check("t2_stop_rd", int'(rom_if.rom_rd), 0);
        check_xyz("t2_stop", 1, 2, 2);
        tick(10);
        check("t2_no_more_rd", rd_addr.size(), 4);
        loop_en = 0;

        // Single-shot steps from address 0
        clear_log();
        for (int i = 0; i < 3; i++) begin
            pulse(0, 0, 1);
            tick(9);
            check("t3_addr", int'(rom_if.rom_addr), exp_addr[i]);
            check("t3_busy", int'(busy), 0);
            check("t3_pv_count", pv_cyc.size(), i + 1);
            check_xyz("t3", exp_x[i], exp_y[i], exp_z[i]);
        end

        // start and stop together from IDLE
        clear_log();
        pulse(1, 1, 0);
        tick(9);
        check("t4_no_rd", rd_addr.size(), 0);
        check("t4_busy", int'(busy), 0);

        // End marker at address 1
        rom_mem[1] = END_WORD;
        clear_log();
        pulse(1, 0, 0);
        tick(15);
        check("t5_pv_count", pv_cyc.size(), 1);
        check("t5_done", int'(done), 1);
        check("t5_rd_count", rd_addr.size(), 2);
        check_xyz("t5", 1, 2, 2);
        pulse(0, 0, 1);
        tick(9);
        check("t5_step_ignored", rd_addr.size(), 2);
        check("t5_still_done", int'(done), 1);
        rom_mem[1] = 30'h0030_0C04;

        // start during HOLD is ignored
        clear_log();
        pulse(1, 0, 0);
        c0 = start_cyc;
        tick(3);
        pulse(1, 0, 0);
        tick(20);
        check("t6_latency", pv_at(0) - c0, 3);
        check("t6_gap0", pv_at(1) - pv_at(0), 7);
        check("t6_gap1", pv_at(2) - pv_at(1), 7);
        check("t6_rd_count", rd_addr.size(), 3);
        check("t6_rd1", rd_at(1), 1);
        check("t6_rd2", rd_at(2), 2);
        check("t6_done", int'(done), 1);

        // Async reset during WAIT of address 1
        clear_log();
        pulse(1, 0, 0);
        found = 0;
        for (int i = 0; i < 20 && found == 0; i++) begin
            if (rom_if.rom_rd && rom_if.rom_addr == 4'd1) found = 1;
            else @(negedge clk);
        end
        check("t7_reach_read1", found, 1);
        @(negedge clk);
        check("t7_pre_busy", int'(busy), 1);
        #2 rst = 0;
        #1;
        check("t7_addr", int'(rom_if.rom_addr), 0);
        check("t7_rd", int'(rom_if.rom_rd), 0);
        check("t7_busy", int'(busy), 0);
        check("t7_done", int'(done), 0);
        check("t7_pv", int'(pos_valid), 0);
        check_xyz("t7", 0, 0, 0);
        @(negedge clk);
        rst = 1;
        @(negedge clk);
        clear_log();
        pulse(1, 0, 0);
        tick(3);
        check("t7_first_rd", rd_at(0), 0);
        check("t7_pv_count", pv_cyc.size(), 1);
        check_xyz("t7_restart", 1, 2, 2);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/arm_sequence_controller.md
# arm_sequence_controller

Sequencer for the robotic-arm position ROM: steps through stored positions at a programmable pace and issues read strobes and addresses. It unpacks each 30-bit word into X/Y/Z coordinates and holds each position for a fixed dwell time. It sits between the debounced one-shot button pulses and the position memory, and its outputs feed the X/Y displays and the Z LEDs directly.

## Interface

- DATA_WIDTH, 30, memory word width; packed as {x[29:20], y[19:10], z[9:0]}
- ADDRESS_WIDTH, 4, memory address width
- NUM_POSITIONS, 16, number of valid entries, 1..2**ADDRESS_WIDTH
- HOLD_CYCLES, 50_000_000, dwell per position in clk cycles, >= 1
- END_MARKER, 30'h3FFF_FFFF, word value that terminates a sequence early

- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-low
- start  in  1  one-cycle pulse: play from address 0
- stop  in  1  one-cycle pulse: abort to IDLE
- step  in  1  one-cycle pulse: fetch a single position (IDLE only)
- loop_en  in  1  level: wrap to address 0 after the last entry instead of finishing
- rom_data  in  DATA_WIDTH  memory read data, valid 1 cycle after rom_rd
- rom_addr  out  ADDRESS_WIDTH  memory address
- rom_rd  out  1  one-cycle read strobe
- x_out, y_out, z_out  out  10 each  current position
- pos_valid  out  1  one-cycle pulse when x/y/z update
- busy  out  1  high in any state other than IDLE and DONE
- done  out  1  high in DONE

## Operation

- States: IDLE, READ, WAIT, HOLD, DONE.
- IDLE: start -> clear rom_addr to 0, go to READ. step -> READ with single-shot flag set; rom_addr keeps its current value.
- READ: assert rom_rd for exactly 1 cycle with rom_addr stable, then go to WAIT.
- WAIT: sample rom_data.
  - If the word equals END_MARKER, x/y/z are not updated, pos_valid stays 0, and the FSM goes to DONE. A single-shot fetch goes to IDLE instead, with rom_addr set to 0.
  - Otherwise load x/y/z from the fields, pulse pos_valid, and go to HOLD. A single-shot fetch goes to IDLE instead, with rom_addr incremented.
- HOLD: the dwell counter counts HOLD_CYCLES cycles, then:
  - rom_addr < NUM_POSITIONS-1: increment rom_addr, go to READ.
  - Last entry with loop_en=1: rom_addr <= 0, go to READ.
  - Last entry with loop_en=0: go to DONE.
- DONE: hold x/y/z. start -> clear rom_addr, go to READ. step is ignored.
- stop, from any state: go to IDLE next cycle, clear the dwell counter and single-shot flag, deassert rom_rd. x/y/z and rom_addr are held, so step resumes from the held address.
- Priority when pulses coincide: stop > start > step. start and step are ignored while busy=1.
- Single-shot increment wraps at NUM_POSITIONS-1 -> 0.
- Dwell counter width is $clog2(HOLD_CYCLES+1). It is cleared on every HOLD entry.

## Timing

- Reset values (asynchronous, rst=0): state IDLE, rom_addr 0, rom_rd 0, x/y/z 0, pos_valid 0, busy 0, done 0, counter 0.
- start at edge N -> READ at N+1 (rom_rd=1) -> WAIT at N+2 -> x/y/z and pos_valid valid after edge N+3.
- Start to first position takes 3 cycles. Each following position arrives HOLD_CYCLES+3 cycles after the previous pos_valid.
- rom_addr changes only on state transitions and never while rom_rd=1.
- All outputs are registered, with no combinational path from input to output.
- Reset asserted mid-sequence returns every output to its reset value immediately. The first start after reset release begins at address 0.

## Test plan

- Reset then start, HOLD_CYCLES=4, NUM_POSITIONS=3, ROM={0x00100802,0x00300C04,0x00501406}, loop_en=0:
  - pos_valid 3 times, spaced 7 cycles apart.
  - x/y/z = (1,2,2), (3,3,4), (5,5,6).
  - done=1 after the third dwell.
  - rom_rd seen exactly 3 times.
- Same stimulus with loop_en=1: after address 2 the controller reads address 0 again and done stays 0. Assert stop mid-HOLD -> IDLE next cycle, busy=0, x/y/z unchanged.
- ROM[1]=END_MARKER, start:
  - One pos_valid carrying address 0 data.
  - Then DONE with no second pos_valid.
  - x/y/z keep the address 0 values.
- In IDLE, 3 step pulses spaced 10 cycles apart:
  - rom_addr goes 0 -> 1 -> 2 -> 0 (NUM_POSITIONS=3).
  - pos_valid once per step.
  - busy returns to 0 after each step.
- start and stop in the same cycle from IDLE -> stays IDLE, no rom_rd. start during HOLD is ignored and the sequence timing is unchanged.
- Assert rst low during WAIT -> all outputs 0 asynchronously. Release, then start -> first read at address 0.
